// File: rtl/dmem_if.sv
// Data-memory bus between core M stage and dmem_responder.
interface dmem_if;
  logic        MemWriteM;
  logic [31:0] ALUResultM;
  logic [31:0] WriteDataM;
  logic [2:0]  funct3M;
  logic [31:0] ReadData;
  logic [7:0]  out_data;
  logic        out_valid;
  logic        out_ready;
  logic        timer_irq;
  logic        misalign_err;

  modport master (
    output MemWriteM, ALUResultM, WriteDataM, funct3M, out_ready,
    input  ReadData, out_data, out_valid, timer_irq, misalign_err
  );

  modport slave (
    input  MemWriteM, ALUResultM, WriteDataM, funct3M, out_ready,
    output ReadData, out_data, out_valid, timer_irq, misalign_err
  );
endinterface

// File: rtl/dmem_responder.sv
// Data RAM plus MMIO block: 64-bit timer/compare, TX byte FIFO, status.
module dmem_responder #(
  parameter int DEPTH_WORDS = 1024,
  parameter int FIFO_DEPTH  = 4
) (
  input logic   clk,
  input logic   rst,
  dmem_if.slave bus
);
  localparam int AW = $clog2(DEPTH_WORDS);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  logic [31:0]   r_mem [DEPTH_WORDS];
  logic [7:0]    r_fifo [FIFO_DEPTH];
  logic [63:0]   r_time;
  logic [63:0]   r_cmp;
  logic [PW-1:0] r_wp;
  logic [PW-1:0] r_rp;
  logic [CW-1:0] r_cnt;
  logic          r_ovf;
  logic          r_mis;
  logic          r_irq;

  logic [31:0]   w_addr;
  logic [31:0]   w_wd;
  logic [2:0]    w_f3;
  logic          w_ram_hit;
  logic          w_mmio_hit;
  logic [AW-1:0] w_idx;
  logic [2:0]    w_reg;

  assign w_addr     = bus.ALUResultM;
  assign w_wd       = bus.WriteDataM;
  assign w_f3       = bus.funct3M;
  assign w_ram_hit  = (w_addr[31:AW+2] == '0);
  assign w_mmio_hit = (w_addr[31:5] == 27'h7FF_F800);
  assign w_idx      = w_addr[AW+1:2];
  assign w_reg      = w_addr[4:2];

  logic          w_full;
  logic          w_empty;
  logic [2:0]    w_cnt3;
  logic [31:0]   w_status;

  assign w_full   = (r_cnt == CW'(FIFO_DEPTH));
  assign w_empty  = (r_cnt == '0);
  assign w_cnt3   = 3'(r_cnt);
  assign w_status = {21'd0, w_cnt3, 3'd0,
                     r_mis, r_irq, r_ovf, w_full, w_empty};

  // Read path: pick word, shift lane down, then size/extend.
  logic [31:0] w_word;
  logic [31:0] w_sh;

  always_comb begin
    w_word = '0;
    if (w_ram_hit) begin
      w_word = r_mem[w_idx];
    end else if (w_mmio_hit) begin
      case (w_reg)
        3'd0:    w_word = r_time[31:0];
        3'd1:    w_word = r_time[63:32];
        3'd2:    w_word = r_cmp[31:0];
        3'd3:    w_word = r_cmp[63:32];
        3'd5:    w_word = w_status;
        default: w_word = '0;
      endcase
    end
  end

  assign w_sh = w_word >> {w_addr[1:0], 3'b000};

  always_comb begin
    bus.ReadData = '0;
    case (w_f3)
      3'b000: bus.ReadData = {{24{w_sh[7]}}, w_sh[7:0]};
      3'b100: bus.ReadData = {24'd0, w_sh[7:0]};
      3'b001: if (!w_addr[0])
                bus.ReadData = {{16{w_sh[15]}}, w_sh[15:0]};
      3'b101: if (!w_addr[0])
                bus.ReadData = {16'd0, w_sh[15:0]};
      3'b010: if (w_addr[1:0] == 2'b00)
                bus.ReadData = w_word;
      default: bus.ReadData = '0;
    endcase
  end

  // Store decode
  logic        w_size_ok;
  logic        w_align;
  logic        w_st;
  logic        w_ram_we;
  logic        w_mis_set;
  logic        w_mmio_we;
  logic [3:0]  w_be;
  logic [31:0] w_wdata;

  always_comb begin
    w_size_ok = 1'b0;
    w_align   = 1'b0;
    w_be      = 4'b0000;
    w_wdata   = w_wd;
    unique case (1'b1)
      (w_f3 == 3'b000): begin
        w_size_ok = 1'b1;
        w_align   = 1'b1;
        w_be      = 4'b0001 << w_addr[1:0];
        w_wdata   = {4{w_wd[7:0]}};
      end
      (w_f3 == 3'b001): begin
        w_size_ok = 1'b1;
        w_align   = !w_addr[0];
        w_be      = w_addr[1] ? 4'b1100 : 4'b0011;
        w_wdata   = {2{w_wd[15:0]}};
      end
      (w_f3 == 3'b010): begin
        w_size_ok = 1'b1;
        w_align   = (w_addr[1:0] == 2'b00);
        w_be      = 4'b1111;
      end
      default: ;
    endcase
  end

  assign w_st      = bus.MemWriteM && w_size_ok;
  assign w_ram_we  = w_st && w_align && w_ram_hit;
  assign w_mis_set = w_st && !w_align && !w_mmio_hit;
  assign w_mmio_we = bus.MemWriteM && w_mmio_hit &&
                     (w_f3 == 3'b010) && (w_addr[1:0] == 2'b00);

  // FIFO handshake; a pop needs a valid head, so push-on-empty wins.
  logic w_push_req;
  logic w_pop;
  logic w_push;
  logic w_ovf_set;
  logic w_clr;

  assign w_push_req = w_mmio_we && (w_reg == 3'd4);
  assign w_pop      = !w_empty && bus.out_ready;
  assign w_push     = w_push_req && (!w_full || w_pop);
  assign w_ovf_set  = w_push_req && w_full && !w_pop;
  assign w_clr      = w_mmio_we && (w_reg == 3'd6);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_time <= '0;
      r_cmp  <= '1;
      r_wp   <= '0;
      r_rp   <= '0;
      r_cnt  <= '0;
      r_ovf  <= 1'b0;
      r_mis  <= 1'b0;
      r_irq  <= 1'b0;
    end else begin
      r_time <= r_time + 64'd1;
      r_irq  <= (r_time >= r_cmp);
      if (w_mmio_we && w_reg == 3'd2) r_cmp[31:0]  <= w_wd;
      if (w_mmio_we && w_reg == 3'd3) r_cmp[63:32] <= w_wd;
      if (w_ram_we) begin
        for (int b = 0; b < 4; b++)
          if (w_be[b]) r_mem[w_idx][8*b +: 8] <= w_wdata[8*b +: 8];
      end
      if (w_push) begin
        r_fifo[r_wp] <= w_wd[7:0];
        r_wp         <= r_wp + PW'(1);
      end
      if (w_pop) r_rp <= r_rp + PW'(1);
      r_cnt <= r_cnt + CW'(w_push) - CW'(w_pop);
      if (w_ovf_set)
        r_ovf <= 1'b1;
      else if (w_clr && w_wd[2])
        r_ovf <= 1'b0;
      if (w_mis_set)
        r_mis <= 1'b1;
      else if (w_clr && w_wd[4])
        r_mis <= 1'b0;
    end
  end

  assign bus.out_data     = r_fifo[r_rp];
  assign bus.out_valid    = !w_empty;
  assign bus.timer_irq    = r_irq;
  assign bus.misalign_err = r_mis;
endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: loads/stores, MMIO timer, TX FIFO.
module tb_dmem_responder;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  dmem_if bus ();

  dmem_responder #(
    .DEPTH_WORDS(1024),
    .FIFO_DEPTH (4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  localparam logic [31:0] MMIO = 32'hFFFF_0000;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic st(input logic [31:0] a,
                    input logic [31:0] d,
                    input logic [2:0]  f);
    @(negedge clk);
    bus.ALUResultM = a;
    bus.WriteDataM = d;
    bus.funct3M    = f;
    bus.MemWriteM  = 1'b1;
    @(negedge clk);
    bus.MemWriteM  = 1'b0;
  endtask

  task automatic ld(input logic [31:0] a,
                    input logic [2:0]  f,
                    output logic [31:0] d);
    bus.ALUResultM = a;
    bus.funct3M    = f;
    #1 d = bus.ReadData;
  endtask

  task automatic lchk(input string tag,
                      input logic [31:0] a,
                      input logic [2:0]  f,
                      input logic [31:0] exp);
    logic [31:0] d;
    ld(a, f, d);
    chk(tag, d, exp);
  endtask

  logic [31:0] s;
  logic [31:0] t;
  logic        seen;

  initial begin
    rst            = 1'b1;
    bus.MemWriteM  = 1'b0;
    bus.ALUResultM = '0;
    bus.WriteDataM = '0;
    bus.funct3M    = 3'b010;
    bus.out_ready  = 1'b0;
    #12;
    chk("rst_valid", bus.out_valid, 0);
    chk("rst_irq", bus.timer_irq, 0);
    chk("rst_mis", bus.misalign_err, 0);
    lchk("rst_time", MMIO + 32'h00, 3'b010, 32'h0);
    lchk("rst_cmp_lo", MMIO + 32'h08, 3'b010, 32'hFFFF_FFFF);
    lchk("rst_status", MMIO + 32'h14, 3'b010, 32'h1);
    @(negedge clk);
    rst = 1'b0;

    // Timer compare: irq visible together with time=21
    st(MMIO + 32'h0C, 32'h0, 3'b010);
    st(MMIO + 32'h08, 32'd20, 3'b010);
    lchk("cmp_lo_rd", MMIO + 32'h08, 3'b010, 32'd20);
    seen = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      ld(MMIO, 3'b010, t);
      if (t == 32'd20) chk("irq_t20", bus.timer_irq, 0);
      if (t == 32'd21) begin
        chk("irq_t21", bus.timer_irq, 1);
        ld(MMIO + 32'h14, 3'b010, s);
        chk("stat_irq", s[3], 1);
        seen = 1'b1;
        break;
      end
    end
    chk("irq_seen", seen, 1);

    // Load lanes and extension
    st(32'h4, 32'h8000_00FF, 3'b010);
    lchk("lb4", 32'h4, 3'b000, 32'hFFFF_FFFF);
    lchk("lbu7", 32'h7, 3'b100, 32'h0000_0080);
    lchk("lhu6", 32'h6, 3'b101, 32'h0000_8000);
    st(32'h4, 32'h1122_3344, 3'b010);
    st(32'h5, 32'h0000_00AB, 3'b000);
    lchk("sb_lw4", 32'h4, 3'b010, 32'h1122_AB44);
    st(32'h6, 32'h0000_BEEF, 3'b001);
    chk("sh_nomis", bus.misalign_err, 0);
    lchk("sh_lw4", 32'h4, 3'b010, 32'hBEEF_AB44);
    lchk("lh6", 32'h6, 3'b001, 32'hFFFF_BEEF);
    lchk("lb5", 32'h5, 3'b000, 32'hFFFF_FFAB);
    lchk("mis_lw5", 32'h5, 3'b010, 32'h0);
    lchk("mis_lh7", 32'h7, 3'b001, 32'h0);
    lchk("unmapped", 32'h0000_1000, 3'b010, 32'h0);
    lchk("tx_rd0", MMIO + 32'h10, 3'b010, 32'h0);

    // Misaligned store suppression and W1C clear
    st(32'h0, 32'h0102_0304, 3'b010);
    st(32'h2, 32'hDEAD_BEEF, 3'b010);
    chk("mis_set", bus.misalign_err, 1);
    lchk("mis_ram", 32'h0, 3'b010, 32'h0102_0304);
    st(MMIO + 32'h18, 32'h10, 3'b010);
    chk("mis_clr", bus.misalign_err, 0);
    st(32'h0, 32'hFFFF_FFFF, 3'b100);
    lchk("bad_f3", 32'h0, 3'b010, 32'h0102_0304);
    chk("bad_f3_mis", bus.misalign_err, 0);

    // FIFO overflow and drain
    for (int k = 1; k <= 5; k++) st(MMIO + 32'h10, k, 3'b010);
    ld(MMIO + 32'h14, 3'b010, s);
    chk("ovf_cnt", s[10:8], 4);
    chk("ovf_bits", s[2:0], 3'b110);
    chk("ovf_head", bus.out_data, 8'h01);
    bus.out_ready = 1'b1;
    #1 chk("pop1", bus.out_data, 8'h01);
    for (int k = 2; k <= 4; k++) begin
      @(negedge clk);
      #1 chk("popk", bus.out_data, k);
    end
    @(negedge clk);
    #1 chk("drained", bus.out_valid, 0);
    bus.out_ready = 1'b0;
    st(MMIO + 32'h18, 32'h4, 3'b010);
    ld(MMIO + 32'h14, 3'b010, s);
    chk("ovf_clr", s[2], 0);

    // Push and pop together while full
    for (int k = 8'h11; k <= 8'h14; k++) st(MMIO + 32'h10, k, 3'b010);
    @(negedge clk);
    bus.ALUResultM = MMIO + 32'h10;
    bus.WriteDataM = 32'h66;
    bus.funct3M    = 3'b010;
    bus.MemWriteM  = 1'b1;
    bus.out_ready  = 1'b1;
    @(negedge clk);
    bus.MemWriteM  = 1'b0;
    bus.out_ready  = 1'b0;
    ld(MMIO + 32'h14, 3'b010, s);
    chk("pp_cnt", s[10:8], 4);
    chk("pp_ovf", s[2], 0);
    chk("pp_head", bus.out_data, 8'h12);
    bus.out_ready = 1'b1;
    repeat (4) @(negedge clk);
    bus.out_ready = 1'b0;
    #1 chk("pp_drain", bus.out_valid, 0);

    // Push and pop together while empty
    @(negedge clk);
    bus.ALUResultM = MMIO + 32'h10;
    bus.WriteDataM = 32'h77;
    bus.MemWriteM  = 1'b1;
    bus.out_ready  = 1'b1;
    @(negedge clk);
    bus.MemWriteM  = 1'b0;
    bus.out_ready  = 1'b0;
    ld(MMIO + 32'h14, 3'b010, s);
    chk("pe_cnt", s[10:8], 1);
    chk("pe_head", bus.out_data, 8'h77);

    // Store on a reset edge is discarded
    st(32'h8, 32'hAAAA_5555, 3'b010);
    @(negedge clk);
    bus.ALUResultM = 32'h8;
    bus.WriteDataM = 32'h1234_5678;
    bus.funct3M    = 3'b010;
    bus.MemWriteM  = 1'b1;
    rst            = 1'b1;
    @(negedge clk);
    bus.MemWriteM  = 1'b0;
    rst            = 1'b0;
    lchk("rst_store", 32'h8, 3'b010, 32'hAAAA_5555);
    chk("rst_fifo", bus.out_valid, 0);

    // Reset mid-operation at time=100 with 3 queued bytes
    for (int k = 8'h21; k <= 8'h23; k++) st(MMIO + 32'h10, k, 3'b010);
    ld(MMIO + 32'h14, 3'b010, s);
    chk("pre_cnt", s[10:8], 3);
    seen = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      ld(MMIO, 3'b010, t);
      if (t == 32'd100) begin
        seen = 1'b1;
        break;
      end
    end
    chk("t100_seen", seen, 1);
    rst = 1'b1;
    #1 chk("mid_valid", bus.out_valid, 0);
    lchk("mid_time", MMIO + 32'h00, 3'b010, 32'h0);
    lchk("mid_status", MMIO + 32'h14, 3'b010, 32'h1);
    @(negedge clk);
    rst = 1'b0;

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
